// File: rtl/serial_nibble_parity_rx_pkg.sv
// Shared types and helpers for the serial nibble receiver and the XOR parity stage it feeds.
package serial_nibble_parity_rx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    PAR  = 2'd2,
    STOP = 2'd3
  } state_e;

  localparam bit PARITY_EVEN = 1'b0;
  localparam bit PARITY_ODD  = 1'b1;

  // Widest vector parity_of accepts; narrower data is zero-extended, which leaves parity unchanged.
  localparam int MAX_DATA_BITS = 32;

  function automatic logic parity_of(input logic [MAX_DATA_BITS-1:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/serial_nibble_parity_rx_if.sv
// Bit-time serial input and parallel nibble/status output of the receiver.
interface serial_nibble_parity_rx_if #(
  parameter int DATA_BITS = 4,
  parameter int ERR_CNT_W = 8
);
  logic                 bit_en;
  logic                 serial_in;
  logic [DATA_BITS-1:0] data_out;
  logic                 out_valid;
  logic                 parity_err;
  logic                 frame_err;
  logic                 busy;
  logic [ERR_CNT_W-1:0] err_cnt;

  modport master (
    output bit_en, serial_in,
    input  data_out, out_valid, parity_err, frame_err, busy, err_cnt
  );

  modport slave (
    input  bit_en, serial_in,
    output data_out, out_valid, parity_err, frame_err, busy, err_cnt
  );
endinterface

// File: rtl/serial_nibble_parity_rx_parity_calc.sv
// Combinational parity check; shares parity_of with the downstream XOR stage so both agree.
module nibble_parity_calc
  import serial_nibble_parity_rx_pkg::*;
#(
  parameter int DATA_BITS  = 4,
  parameter bit ODD_PARITY = PARITY_EVEN
) (
  input  logic [DATA_BITS-1:0] data,
  input  logic                 par_bit,
  output logic                 err
);
  assign err = (parity_of(MAX_DATA_BITS'(data)) ^ par_bit) != ODD_PARITY;
endmodule

// File: rtl/serial_nibble_parity_rx.sv
// Deserializes start/data(LSB-first)/parity/stop frames into a nibble with parity/framing flags.
module serial_nibble_parity_rx
  import serial_nibble_parity_rx_pkg::state_e, serial_nibble_parity_rx_pkg::IDLE,
         serial_nibble_parity_rx_pkg::DATA, serial_nibble_parity_rx_pkg::PAR,
         serial_nibble_parity_rx_pkg::STOP;
#(
  parameter int DATA_BITS  = 4,
  parameter bit PARITY_ODD = 1'b0,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  serial_nibble_parity_rx_if.slave  bus
);
  localparam int            CW       = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DATA_BITS - 1);

  state_e               state_q,   state_d;
  logic [DATA_BITS-1:0] shift_q,   shift_d;
  logic [CW-1:0]        cnt_q,     cnt_d;
  logic                 par_q,     par_d;
  logic [DATA_BITS-1:0] data_q,    data_d;
  logic                 valid_q,   valid_d;
  logic                 perr_q,    perr_d;
  logic                 ferr_q,    ferr_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic                 calc_err;

  nibble_parity_calc #(
    .DATA_BITS  (DATA_BITS),
    .ODD_PARITY (PARITY_ODD)
  ) u_parity (
    .data    (shift_q),
    .par_bit (par_q),
    .err     (calc_err)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    par_d     = par_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    err_cnt_d = err_cnt_q;
    if (bus.bit_en) begin
      case (state_q)
        IDLE: begin
          if (!bus.serial_in) begin
            state_d = DATA;
            cnt_d   = '0;
          end
        end
        DATA: begin
          // Shift in at the MSB so the first data bit lands in bit0 after DATA_BITS shifts.
          shift_d = {bus.serial_in, shift_q[DATA_BITS-1:1]};
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) state_d = PAR;
        end
        PAR: begin
          par_d   = bus.serial_in;
          state_d = STOP;
        end
        STOP: begin
          data_d  = shift_q;
          valid_d = 1'b1;
          perr_d  = calc_err;
          ferr_d  = ~bus.serial_in;
          if ((calc_err || !bus.serial_in) && err_cnt_q != '1)
            err_cnt_d = err_cnt_q + 1'b1;
          // A zero stop bit is consumed here; it never doubles as the next start bit.
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      cnt_q     <= '0;
      par_q     <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      par_q     <= par_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign bus.data_out   = data_q;
  assign bus.out_valid  = valid_q;
  assign bus.parity_err = perr_q;
  assign bus.frame_err  = ferr_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_serial_nibble_parity_rx.sv
// Directed bench: frame-level model checked every cycle against two receivers (8-bit and 2-bit error counters).
module tb_serial_nibble_parity_rx;
  logic clk;
  logic rst_n;
  logic bit_en;
  logic serial_in;
  logic chk_en;

  int n_chk  = 0;
  int n_fail = 0;

  // Frame-level expectations
  logic       m_valid, m_perr, m_ferr, m_busy;
  logic [3:0] m_data;
  int         m_cnt_a, m_cnt_b;

  serial_nibble_parity_rx_if #(.DATA_BITS(4), .ERR_CNT_W(8)) ifa ();
  serial_nibble_parity_rx_if #(.DATA_BITS(4), .ERR_CNT_W(2)) ifb ();

  assign ifa.bit_en    = bit_en;
  assign ifa.serial_in = serial_in;
  assign ifb.bit_en    = bit_en;
  assign ifb.serial_in = serial_in;

  serial_nibble_parity_rx #(.DATA_BITS(4), .PARITY_ODD(1'b0), .ERR_CNT_W(8)) dut_a (
    .clk (clk), .rst_n (rst_n), .bus (ifa)
  );
  serial_nibble_parity_rx #(.DATA_BITS(4), .PARITY_ODD(1'b0), .ERR_CNT_W(2)) dut_b (
    .clk (clk), .rst_n (rst_n), .bus (ifb)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_perr = 0; m_ferr = 0; m_busy = 0; m_data = 0; m_cnt_a = 0; m_cnt_b = 0;
  endtask

  // One clock with the given bit_en/serial_in; returns 1 time unit after the rising edge.
  task automatic step(input logic en, input logic b);
    bit_en    = en;
    serial_in = b;
    @(posedge clk);
    #1;
    m_valid = 0;
  endtask

  // Full frame with `gap` non-tick cycles before every tick; updates the model after the stop tick.
  task automatic send_frame(input logic [3:0] d, input logic par, input logic stp, input int gap);
    logic [6:0] bits;
    bits = {stp, par, d, 1'b0};
    for (int i = 0; i < 7; i++) begin
      for (int g = 0; g < gap; g++) step(1'b0, ~bits[i]);
      step(1'b1, bits[i]);
      if (i == 0) m_busy = 1;
    end
    m_busy  = 0;
    m_valid = 1;
    m_data  = d;
    m_perr  = ((^d) ^ par) != 1'b0;
    m_ferr  = ~stp;
    if (m_perr || m_ferr) begin
      m_cnt_a = (m_cnt_a == 255) ? 255 : m_cnt_a + 1;
      m_cnt_b = (m_cnt_b == 3)   ? 3   : m_cnt_b + 1;
    end
  endtask

  task automatic reset_pulse();
    #2;
    rst_n = 0;
    model_reset();
    #1;
    chk("async_rst_data", 32'(ifa.data_out), 0);
    chk("async_rst_busy", 32'(ifa.busy), 0);
    chk("async_rst_cnt",  32'(ifa.err_cnt), 0);
    chk("async_rst_perr", 32'(ifa.parity_err), 0);
    step(1'b1, 1'b1);
    rst_n = 1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("valid",   32'(ifa.out_valid),  32'(m_valid));
      chk("data",    32'(ifa.data_out),   32'(m_data));
      chk("perr",    32'(ifa.parity_err), 32'(m_perr));
      chk("ferr",    32'(ifa.frame_err),  32'(m_ferr));
      chk("busy",    32'(ifa.busy),       32'(m_busy));
      chk("cnt_a",   32'(ifa.err_cnt),    32'(m_cnt_a));
      chk("valid_b", 32'(ifb.out_valid),  32'(m_valid));
      chk("data_b",  32'(ifb.data_out),   32'(m_data));
      chk("cnt_b",   32'(ifb.err_cnt),    32'(m_cnt_b));
    end
  end

  int sat_exp [5] = '{1, 2, 3, 3, 3};

  initial begin
    clk = 0; rst_n = 0; bit_en = 0; serial_in = 1; chk_en = 0;
    model_reset();
    #2;
    chk("rst_data",  32'(ifa.data_out), 0);
    chk("rst_valid", 32'(ifa.out_valid), 0);
    chk("rst_perr",  32'(ifa.parity_err), 0);
    chk("rst_ferr",  32'(ifa.frame_err), 0);
    chk("rst_busy",  32'(ifa.busy), 0);
    chk("rst_cnt_a", 32'(ifa.err_cnt), 0);
    chk("rst_cnt_b", 32'(ifb.err_cnt), 0);
    #10 rst_n = 1;
    chk_en = 1;
    step(1'b0, 1'b1);

    // Even-parity good frame 4'hB
    send_frame(4'hB, 1'b1, 1'b1, 0);
    chk("good_data",  32'(ifa.data_out), 32'hB);
    chk("good_valid", 32'(ifa.out_valid), 1);
    chk("good_perr",  32'(ifa.parity_err), 0);
    chk("good_ferr",  32'(ifa.frame_err), 0);
    chk("good_cnt",   32'(ifa.err_cnt), 0);
    step(1'b1, 1'b1);
    chk("good_pulse_end", 32'(ifa.out_valid), 0);

    // Parity error
    send_frame(4'hB, 1'b0, 1'b1, 0);
    chk("perr_data", 32'(ifa.data_out), 32'hB);
    chk("perr_flag", 32'(ifa.parity_err), 1);
    chk("perr_cnt",  32'(ifa.err_cnt), 1);
    step(1'b1, 1'b1);
    chk("perr_hold", 32'(ifa.parity_err), 1);

    // Framing error then back-to-back recovery
    send_frame(4'h6, 1'b0, 1'b0, 0);
    chk("ferr_flag", 32'(ifa.frame_err), 1);
    chk("ferr_perr", 32'(ifa.parity_err), 0);
    chk("ferr_cnt",  32'(ifa.err_cnt), 2);
    send_frame(4'h3, 1'b0, 1'b1, 0);
    chk("recov_data", 32'(ifa.data_out), 32'h3);
    chk("recov_ferr", 32'(ifa.frame_err), 0);
    chk("recov_perr", 32'(ifa.parity_err), 0);
    step(1'b1, 1'b1);

    // bit_en every 4th cycle
    send_frame(4'hF, 1'b0, 1'b1, 3);
    chk("gate_data",  32'(ifa.data_out), 32'hF);
    chk("gate_valid", 32'(ifa.out_valid), 1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);

    // Reset after two data bits, then a clean frame
    step(1'b1, 1'b0); m_busy = 1;
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    reset_pulse();
    send_frame(4'hA, 1'b0, 1'b1, 0);
    chk("post_rst_data", 32'(ifa.data_out), 32'hA);
    chk("post_rst_cnt",  32'(ifa.err_cnt), 0);
    step(1'b1, 1'b1);

    // Saturation of the 2-bit counter
    reset_pulse();
    for (int k = 0; k < 5; k++) begin
      send_frame(4'hB, 1'b0, 1'b1, 0);
      chk("sat_cnt_b", 32'(ifb.err_cnt), 32'(sat_exp[k]));
    end
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    chk_en = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
